ssp_tx_fifo_gen: RTL and testbench
==================================

# ssp_tx_fifo_gen

Parametrised transmit FIFO for the SSP block, sitting between the APB write path and the transmit shift register. It buffers CPU-written words of configurable width and depth and exposes a fill-level count. It also provides a programmable watermark interrupt, a sticky overflow flag, and a registered output word with a one-cycle valid strobe. It supersedes the fixed 8x4 transmit FIFO and allows push-while-full when a pop occurs in the same cycle.

## Interface
- DATA_W, 8, word width in bits (1..32)
- DEPTH, 4, number of entries; power of two, 2..256
- TX_WM, DEPTH/2, watermark: interrupt when level <= TX_WM (0..DEPTH-1)
- LVL_W, $clog2(DEPTH)+1, width of level output (derived, not overridden)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- CLEAR_B  in  1  reset, synchronous, active-low
- PSEL  in  1  APB select for the TX data register
- PWRITE  in  1  APB write strobe
- PWDATA  in  DATA_W  word to push
- TXIM  in  1  interrupt mask; 1 = SSPTXINTR enabled
- ovr_clr  in  1  clears sticky overflow flag
- shf_read_ready  in  1  shifter requests next word
- TxData  out  DATA_W  registered head word, updated on pop
- tx_valid  out  1  one-cycle strobe: TxData updated this cycle
- fifo_empty  out  1  level == 0
- fifo_full  out  1  level == DEPTH
- level  out  LVL_W  current occupancy, 0..DEPTH
- SSPTXINTR  out  1  TXIM && (level <= TX_WM)
- tx_ovr  out  1  sticky: push attempted while full with no pop

## Operation
- pop = shf_read_ready && !fifo_empty. PWRITE does not gate pop.
- wr_req = PSEL && PWRITE.
- push = wr_req && (!fifo_full || pop).
- On push: mem[wr_ptr] <= PWDATA; wr_ptr advances by 1, mod DEPTH.
- On pop: TxData <= mem[rd_ptr]; rd_ptr advances by 1, mod DEPTH; tx_valid <= 1. Otherwise tx_valid <= 0 and TxData holds.
- level update: push only, +1; pop only, -1; both or neither, unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally; level is the full/empty authority.
- When full, push and pop in the same cycle: the pop reads the old head and the push writes the freed slot (wr_ptr == rd_ptr). Level stays DEPTH.
- When empty, wr_req and shf_read_ready in the same cycle: push only, no pop. The word appears at TxData on a later pop, with no fall-through.
- wr_req while full with no pop: the word is dropped, storage and pointers are unchanged, and tx_ovr <= 1.
- ovr_clr: tx_ovr <= 0. If ovr_clr and a new overflow occur in the same cycle, the set wins.
- fifo_empty, fifo_full and SSPTXINTR are combinational from level and TXIM.
- Reset (CLEAR_B=0 at an edge) has priority over all other activity, including mid-transfer:
  - wr_ptr, rd_ptr, level <= 0; TxData <= 0; tx_valid <= 0; tx_ovr <= 0.
  - Storage contents are not cleared and are don't-care.
  - After reset: fifo_empty=1, fifo_full=0, and SSPTXINTR=TXIM (level 0 <= TX_WM).

## Timing
- Push to level visible: 1 cycle.
- Pop request to TxData/tx_valid: 1 cycle, registered.
- Write to earliest pop of that word: request in cycle N+1 gives TxData in N+2.
- Sustained throughput: 1 push and 1 pop per cycle at any level.
- SSPTXINTR and full/empty follow level with no extra delay.

## Structure
- Shared package ssp_pkg:
  - clog2 helper.
  - Default DATA_W/DEPTH constants.
  - Level-width localparam formula.
- One sub-module, ssp_fifo_mem: DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port. Control, level, flags and the output register stay in ssp_tx_fifo_gen.

## Test plan
- Reset and fill (DEPTH=4, TXIM=1):
  - After reset: level=0, fifo_empty=1, SSPTXINTR=1, TxData=0.
  - Push 0x11,0x22,0x33,0x44: level=4, fifo_full=1, SSPTXINTR=0 once level>2.
- Overflow: from full, push 0x55 with no pop -> tx_ovr=1, level stays 4. Pops then yield 0x11,0x22,0x33,0x44, never 0x55. ovr_clr clears tx_ovr.
- Full push+pop: from full (0x11..0x44), wr_req 0x55 with shf_read_ready -> TxData=0x11, tx_valid=1, level=4. The next four pops yield 0x22,0x33,0x44,0x55.
- Empty corner: empty FIFO, wr_req 0xA5 and shf_read_ready in the same cycle -> no tx_valid, level=1. The next pop gives TxData=0xA5.
- Wrap and streaming (DEPTH=8, DATA_W=16): 40 words 0x0000..0x0027 with push and pop every cycle after priming -> in-order output, level constant, no tx_ovr.
- Reset mid-operation: level=3, CLEAR_B low for one cycle while wr_req and shf_read_ready are high -> all state per reset values, no tx_valid; a subsequent push/pop of 0x7E returns 0x7E.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared SSP definitions: default FIFO geometry and width helpers.
package ssp_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  // Ceiling log2 usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Level must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int lvl_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ssp_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
module ssp_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset; level decides what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_tx_fifo_gen.sv
// SSP transmit FIFO: buffers APB writes for the shifter, with level,
// watermark interrupt, sticky overflow and a registered output word.
module ssp_tx_fifo_gen
  import ssp_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int TX_WM  = DEPTH / 2,
  localparam int LVL_W  = lvl_width(DEPTH)
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              PSEL,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              TXIM,
  input  logic              ovr_clr,
  input  logic              shf_read_ready,
  output logic [DATA_W-1:0] TxData,
  output logic              tx_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [LVL_W-1:0]  level,
  output logic              SSPTXINTR,
  output logic              tx_ovr
);

  localparam int PTR_W = clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] head;
  logic              wr_req;
  logic              pop;
  logic              push;
  logic              overflow;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(DEPTH));
  assign SSPTXINTR  = TXIM && (level <= LVL_W'(TX_WM));

  assign wr_req   = PSEL && PWRITE;
  assign pop      = shf_read_ready && !fifo_empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push     = wr_req && (!fifo_full || pop);
  assign overflow = wr_req && fifo_full && !pop;

  ssp_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (PCLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (PWDATA),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      TxData   <= '0;
      tx_valid <= 1'b0;
      tx_ovr   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        TxData <= head;
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      tx_valid <= pop;
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (overflow)     tx_ovr <= 1'b1;
      else if (ovr_clr) tx_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssp_tx_fifo_gen.sv
// Bench for ssp_tx_fifo_gen: directed corners plus random traffic on a
// DEPTH=4/8-bit and a DEPTH=8/16-bit instance, checked against queue models.
module tb_ssp_tx_fifo_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic CLEAR_B;

  logic       a_sel, a_wr, a_txim, a_clr, a_rdy;
  logic [7:0] a_wdata, a_txdata;
  logic       a_valid, a_empty, a_full, a_intr, a_ovr;
  logic [2:0] a_level;

  logic        b_sel, b_wr, b_txim, b_clr, b_rdy;
  logic [15:0] b_wdata, b_txdata;
  logic        b_valid, b_empty, b_full, b_intr, b_ovr;
  logic [3:0]  b_level;

  ssp_tx_fifo_gen u_a (
    .PCLK (clk), .CLEAR_B (CLEAR_B), .PSEL (a_sel), .PWRITE (a_wr),
    .PWDATA (a_wdata), .TXIM (a_txim), .ovr_clr (a_clr),
    .shf_read_ready (a_rdy), .TxData (a_txdata), .tx_valid (a_valid),
    .fifo_empty (a_empty), .fifo_full (a_full), .level (a_level),
    .SSPTXINTR (a_intr), .tx_ovr (a_ovr)
  );

  ssp_tx_fifo_gen #(.DATA_W (16), .DEPTH (8)) u_b (
    .PCLK (clk), .CLEAR_B (CLEAR_B), .PSEL (b_sel), .PWRITE (b_wr),
    .PWDATA (b_wdata), .TXIM (b_txim), .ovr_clr (b_clr),
    .shf_read_ready (b_rdy), .TxData (b_txdata), .tx_valid (b_valid),
    .fifo_empty (b_empty), .fifo_full (b_full), .level (b_level),
    .SSPTXINTR (b_intr), .tx_ovr (b_ovr)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: the FIFO is a queue of words; everything else follows.
  logic [31:0] mq [2][$];
  logic [31:0] m_tx  [2];
  bit          m_val [2];
  bit          m_ovr [2];
  int          m_depth [2] = '{4, 8};
  int          m_wm    [2] = '{2, 4};

  task automatic model_step(input int i, input bit rst_n, input bit wr_req,
                            input bit rdy, input logic [31:0] d, input bit clr);
    bit can_pop, full;
    if (!rst_n) begin
      mq[i].delete();
      m_tx[i]  = '0;
      m_val[i] = 1'b0;
      m_ovr[i] = 1'b0;
    end else begin
      can_pop = rdy && (mq[i].size() > 0);
      full    = (mq[i].size() == m_depth[i]);
      m_val[i] = can_pop;
      if (can_pop) m_tx[i] = mq[i].pop_front();
      if (wr_req && (!full || can_pop)) mq[i].push_back(d);
      if (wr_req && full && !can_pop) m_ovr[i] = 1'b1;
      else if (clr)                   m_ovr[i] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sa, sb;
    sa = mq[0].size();
    sb = mq[1].size();
    chk("a_level", 32'(a_level), 32'(sa));
    chk("a_empty", 32'(a_empty), 32'(sa == 0));
    chk("a_full",  32'(a_full),  32'(sa == m_depth[0]));
    chk("a_intr",  32'(a_intr),  32'(a_txim && (sa <= m_wm[0])));
    chk("a_valid", 32'(a_valid), 32'(m_val[0]));
    chk("a_txdata", 32'(a_txdata), m_tx[0]);
    chk("a_ovr",   32'(a_ovr),   32'(m_ovr[0]));
    chk("b_level", 32'(b_level), 32'(sb));
    chk("b_empty", 32'(b_empty), 32'(sb == 0));
    chk("b_full",  32'(b_full),  32'(sb == m_depth[1]));
    chk("b_intr",  32'(b_intr),  32'(b_txim && (sb <= m_wm[1])));
    chk("b_valid", 32'(b_valid), 32'(m_val[1]));
    chk("b_txdata", 32'(b_txdata), m_tx[1]);
    chk("b_ovr",   32'(b_ovr),   32'(m_ovr[1]));
  endtask

  task automatic tick();
    model_step(0, CLEAR_B, a_sel && a_wr, a_rdy, 32'(a_wdata), a_clr);
    model_step(1, CLEAR_B, b_sel && b_wr, b_rdy, 32'(b_wdata), b_clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic a_drive(input bit wr, input logic [7:0] d, input bit rdy, input bit clr);
    a_sel = wr; a_wr = wr; a_wdata = d; a_rdy = rdy; a_clr = clr;
  endtask

  task automatic b_drive(input bit wr, input logic [15:0] d, input bit rdy, input bit clr);
    b_sel = wr; b_wr = wr; b_wdata = d; b_rdy = rdy; b_clr = clr;
  endtask

  initial begin
    logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    CLEAR_B = 1'b0;
    a_txim = 1'b1; b_txim = 1'b1;
    a_drive(0, '0, 0, 0);
    b_drive(0, '0, 0, 0);
    tick();
    tick();

    // Reset state then fill A to full.
    CLEAR_B = 1'b1;
    tick();
    foreach (fill[k]) begin
      a_drive(1, fill[k], 0, 0);
      tick();
    end

    // Overflow: dropped word, sticky flag, then drain and clear.
    a_drive(1, 8'h55, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      a_drive(0, '0, 1, 0);
      tick();
    end
    a_drive(0, '0, 1, 1);
    tick();

    // Refill; overflow coinciding with ovr_clr keeps the flag set.
    foreach (fill[k]) begin
      a_drive(1, fill[k], 0, 0);
      tick();
    end
    a_drive(1, 8'h66, 0, 1);
    tick();
    a_drive(0, '0, 0, 1);
    tick();

    // Push and pop together while full.
    a_drive(1, 8'h55, 1, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      a_drive(0, '0, 1, 0);
      tick();
    end

    // Empty: simultaneous write and read request must not fall through.
    a_drive(1, 8'hA5, 1, 0);
    tick();
    a_drive(0, '0, 1, 0);
    tick();

    // Reset in the middle of traffic at level 3.
    for (int k = 0; k < 3; k++) begin
      a_drive(1, 8'(k + 1), 0, 0);
      tick();
    end
    CLEAR_B = 1'b0;
    a_drive(1, 8'h99, 1, 0);
    tick();
    CLEAR_B = 1'b1;
    a_drive(1, 8'h7E, 0, 0);
    tick();
    a_drive(0, '0, 1, 0);
    tick();
    a_drive(0, '0, 0, 0);

    // Streaming on B: prime 4 words, then push and pop every cycle.
    for (int k = 0; k < 40; k++) begin
      b_drive(1, 16'(k), k >= 4, 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      b_drive(0, '0, 1, 0);
      tick();
    end

    // Random traffic on both instances with occasional reset.
    for (int n = 0; n < 400; n++) begin
      CLEAR_B = ($urandom_range(0, 63) != 0);
      a_txim = 1'($urandom_range(0, 7) != 0);
      b_txim = 1'($urandom_range(0, 7) != 0);
      a_sel = 1'($urandom_range(0, 3) != 0);
      a_wr  = 1'($urandom_range(0, 3) != 0);
      a_wdata = 8'($urandom);
      a_rdy = 1'($urandom_range(0, 1));
      a_clr = ($urandom_range(0, 7) == 0);
      b_sel = 1'($urandom_range(0, 3) != 0);
      b_wr  = 1'($urandom_range(0, 3) != 0);
      b_wdata = 16'($urandom);
      b_rdy = ($urandom_range(0, 2) == 0);
      b_clr = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
